// File: rtl/mopshub_elink_traffic_gen.sv
// mopshub_elink_traffic_gen: multi-channel uplink frame generator driving the mopshubCore elink handshake
module mopshub_elink_traffic_gen #(
  parameter int N_CH = 8,
  parameter int CH_W = 5,
  parameter int DATA_W = 48,
  parameter int GAP = 4,
  parameter int TIMEOUT = 1023,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345,
  localparam int FRAME_W = 28 + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               loop_en,
  input  logic [1:0]         mode,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [15:0]        n_msg,
  input  logic               start_read_elink,
  input  logic               end_read_elink,
  input  logic               end_send_msg,
  output logic               irq_elink,
  output logic [FRAME_W-1:0] payload,
  output logic [11:0]        canid,
  output logic [CH_W-1:0]    chan,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic [15:0]        msg_cnt,
  output logic [7:0]         err_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_GAP, S_REQ, S_READ, S_WAIT, S_NEXT, S_FIN} state_t;
  state_t             state_q;
  logic [31:0]        gap_q, tmo_q, lfsr_q, lfsr_n;
  logic [15:0]        att_q, n_q, msg_cnt_q;
  logic [7:0]         seq_q, err_cnt_q;
  logic [CH_W-1:0]    chan_q, low_ch, nxt_ch;
  logic [FRAME_W-1:0] payload_q;
  logic               irq_q, done_q, err_to_q, last;

  function automatic logic bit_at(input logic [N_CH-1:0] v, input int p);
    logic [N_CH-1:0] s;
    s = v >> p;
    return s[0];
  endfunction

  function automatic logic [FRAME_W-1:0] mk_frame(input logic [CH_W-1:0] ch, input logic [7:0] s,
                                                  input logic [7:0] mc, input logic [31:0] l,
                                                  input logic [1:0] m);
    logic [63:0] w;
    w = (m == 2'd1) ? {l, l} : {48'd0, s, mc};
    return {8'(ch), 12'h600 + 12'(ch) + 12'd1, s, w[DATA_W-1:0]};
  endfunction

  assign last   = (att_q + 16'd1) == n_q;
  assign lfsr_n = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? 32'h0040_0007 : 32'h0);

  // lowest enabled channel for a fresh start, next enabled channel after the current one (wrapping)
  always_comb begin
    low_ch = '0;
    nxt_ch = chan_q;
    for (int i = N_CH - 1; i >= 0; i--) if (bit_at(ch_mask, i)) low_ch = CH_W'(i);
    for (int i = N_CH; i >= 1; i--) if (bit_at(ch_mask, (int'(chan_q) + i) % N_CH)) nxt_ch = CH_W'((int'(chan_q) + i) % N_CH);
  end

  // sequencer: frame build, handshake tracking, timeout and counters, all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      tmo_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      att_q     <= '0;
      n_q       <= '0;
      msg_cnt_q <= '0;
      seq_q     <= '0;
      err_cnt_q <= '0;
      chan_q    <= '0;
      payload_q <= '0;
      irq_q     <= 1'b0;
      done_q    <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_to_q <= 1'b0;
      case (state_q)
        S_IDLE: if (en) begin
          msg_cnt_q <= '0;
          err_cnt_q <= '0;
          if (ch_mask != '0 && n_msg != '0) begin
            chan_q    <= low_ch;
            seq_q     <= '0;
            att_q     <= '0;
            n_q       <= n_msg;
            payload_q <= mk_frame(low_ch, 8'd0, 8'd0, lfsr_q, mode);
            state_q   <= (GAP == 0) ? S_REQ : S_GAP;
            irq_q     <= (GAP == 0);
            gap_q     <= '0;
            tmo_q     <= '0;
          end else state_q <= S_FIN;
        end
        S_GAP: if (gap_q == 32'(GAP - 1)) begin
          state_q <= S_REQ;
          irq_q   <= 1'b1;
          tmo_q   <= '0;
        end else gap_q <= gap_q + 32'd1;
        S_REQ, S_READ, S_WAIT: if (state_q == S_WAIT && end_send_msg) begin
          state_q   <= S_NEXT;
          msg_cnt_q <= msg_cnt_q + 16'd1;
        end else if (tmo_q == 32'(TIMEOUT)) begin
          state_q  <= S_NEXT;
          irq_q    <= 1'b0;
          err_to_q <= 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end else begin
          tmo_q <= tmo_q + 32'd1;
          if (state_q == S_REQ && start_read_elink) begin
            state_q <= S_READ;
            irq_q   <= 1'b0;
          end
          if (state_q == S_READ && end_read_elink) state_q <= S_WAIT;
        end
        S_NEXT: begin
          chan_q    <= nxt_ch;
          seq_q     <= seq_q + 8'd1;
          lfsr_q    <= lfsr_n;
          payload_q <= mk_frame(nxt_ch, seq_q + 8'd1, (last && loop_en) ? 8'd0 : msg_cnt_q[7:0], lfsr_n, mode);
          if (last && !loop_en) state_q <= S_FIN;
          else begin
            att_q   <= last ? 16'd0 : att_q + 16'd1;
            if (last) msg_cnt_q <= '0;
            state_q <= (GAP == 0) ? S_REQ : S_GAP;
            irq_q   <= (GAP == 0);
            gap_q   <= '0;
            tmo_q   <= '0;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign irq_elink   = irq_q;
  assign payload     = payload_q;
  assign canid       = payload_q[DATA_W+8 +: 12];
  assign chan        = chan_q;
  assign busy        = state_q != S_IDLE;
  assign done        = done_q;
  assign err_timeout = err_to_q;
  assign msg_cnt     = msg_cnt_q;
  assign err_cnt     = err_cnt_q;
endmodule
